fetch_stage: RTL and testbench

- IF stage of the five-stage RV32 pipeline.
- Owns the PC register and the instruction-memory request/response handshake. Drives the IF/ID pipeline register that feeds the decode stage (InstrD, PCD, PCPlus4D).
- Honours hazard-unit stall/flush and EX-stage branch/jump redirects.
- Keeps at most one memory request outstanding and has a 1-entry skid buffer, so variable-latency memory never drops an instruction.

---
 rtl/fetch_stage.sv | 136 +++++++++++++
 tb/tb_fetch_stage.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// IF stage: owns PCF, runs the single-outstanding imem handshake and feeds IF/ID.
// A one-entry skid buffer holds a response that lands while decode is stalled.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemValid,
    input  logic [31:0] ImemRdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pcf;
    logic [31:0] r_req_pc;
    logic        r_buf_vld;
    logic [31:0] r_buf_instr;
    logic [31:0] r_buf_pc;
    logic        r_vld_d;
    logic [31:0] r_instr_d;
    logic [31:0] r_pc_d;
    logic [31:0] r_pc4_d;

    logic        w_accept;
    logic        w_buf_nxt_vld;
    logic        w_issue;

    // A response is only kept in WAIT; a same-cycle redirect makes it wrong-path.
    assign w_accept      = (r_state == S_WAIT) && ImemValid && !PCSrcE;
    assign w_buf_nxt_vld = StallD && !FlushD && !PCSrcE && (r_buf_vld || w_accept);
    assign w_issue       = !RST && !StallF && !PCSrcE &&
                           ((r_state == S_IDLE) || ((r_state == S_WAIT) && ImemValid)) &&
                           !w_buf_nxt_vld;

    assign ImemReq  = w_issue;
    assign ImemAddr = r_pcf;

    assign InstrD   = r_instr_d;
    assign PCD      = r_pc_d;
    assign PCPlus4D = r_pc4_d;
    assign ValidD   = r_vld_d;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_issue) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (PCSrcE)         w_state_nxt = ImemValid ? S_IDLE : S_DRAIN;
                else if (ImemValid) w_state_nxt = w_issue ? S_WAIT : S_IDLE;
            end
            S_DRAIN: begin
                if (ImemValid) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_pcf    <= RESET_PC;
            r_req_pc <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            if (PCSrcE) begin
                r_pcf <= PCTargetE;
            end else if (w_issue) begin
                r_req_pc <= r_pcf;
                r_pcf    <= r_pcf + 32'd4;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_buf_vld   <= 1'b0;
            r_buf_instr <= NOP_INSTR;
            r_buf_pc    <= 32'h0;
        end else begin
            r_buf_vld <= w_buf_nxt_vld;
            if (StallD && !FlushD && w_accept && !r_buf_vld) begin
                r_buf_instr <= ImemRdata;
                r_buf_pc    <= r_req_pc;
            end
        end
    end

    // Bubbles keep the previous PCD/PCPlus4D; only the instruction and valid change.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_vld_d   <= 1'b0;
            r_instr_d <= NOP_INSTR;
            r_pc_d    <= 32'h0;
            r_pc4_d   <= 32'h0;
        end else if (FlushD) begin
            r_vld_d   <= 1'b0;
            r_instr_d <= NOP_INSTR;
        end else if (!StallD) begin
            if (r_buf_vld && !PCSrcE) begin
                r_vld_d   <= 1'b1;
                r_instr_d <= r_buf_instr;
                r_pc_d    <= r_buf_pc;
                r_pc4_d   <= r_buf_pc + 32'd4;
            end else if (w_accept) begin
                r_vld_d   <= 1'b1;
                r_instr_d <= ImemRdata;
                r_pc_d    <= r_req_pc;
                r_pc4_d   <= r_req_pc + 32'd4;
            end else begin
                r_vld_d   <= 1'b0;
                r_instr_d <= NOP_INSTR;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: variable-latency memory plus a transaction-level model
// (expected fetch PC, queue of arrived-but-undelivered instructions, IF/ID contents).
module tb_fetch_stage;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] XORK = 32'hA5A5_0000;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RST = 1'b1, StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0;
    logic        ImemValid = 1'b0;
    logic [31:0] PCTargetE = 32'h0, ImemRdata = 32'h0;
    logic        ImemReq, ValidD;
    logic [31:0] ImemAddr, InstrD, PCD, PCPlus4D;

    logic        z1 = 1'b0;
    logic [31:0] z32 = 32'h0;
    logic        ImemValid2 = 1'b0;
    logic        ImemReq2, ValidD2;
    logic [31:0] ImemAddr2, InstrD2, PCD2, PCPlus4D2;

    fetch_stage u_dut (
        .CLK(CLK), .RST(RST), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
        .ImemValid(ImemValid), .ImemRdata(ImemRdata), .InstrD(InstrD), .PCD(PCD),
        .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .CLK(CLK), .RST(RST), .StallF(z1), .StallD(z1), .FlushD(z1),
        .PCSrcE(z1), .PCTargetE(z32), .ImemReq(ImemReq2), .ImemAddr(ImemAddr2),
        .ImemValid(ImemValid2), .ImemRdata(z32), .InstrD(InstrD2), .PCD(PCD2),
        .PCPlus4D(PCPlus4D2), .ValidD(ValidD2)
    );

    int n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Memory / reference model state
    logic [31:0] exp_pc = 32'h0;
    bit          pend = 0, pkill = 0;
    int          pcnt = 0;
    logic [31:0] paddr = 32'h0;
    logic [31:0] q[$];
    bit          md_v = 0;
    logic [31:0] md_i = NOP, md_pc = 32'h0, md_pc4 = 32'h0;
    int          lat_fix = 1;
    bit          req2_prev = 0;
    int          n2 = 0;

    task automatic step(input bit rst, input bit sf, input bit sd, input bit fd,
                        input bit ps, input logic [31:0] tgt);
        bit          mv, mk, arr, exp_req;
        logic [31:0] ma;
        @(negedge CLK);
        mv = 0; mk = 0; ma = 32'h0;
        if (rst) pend = 0;
        else if (pend) begin
            if (pcnt == 1) begin mv = 1; mk = pkill; ma = paddr; pend = 0; end
            else pcnt--;
        end
        RST = rst; StallF = sf; StallD = sd; FlushD = fd; PCSrcE = ps; PCTargetE = tgt;
        ImemValid = mv;
        ImemRdata = mv ? (ma ^ XORK) : $urandom;
        ImemValid2 = req2_prev && !rst;
        #1;
        // Decode-side view: what IF/ID holds after this edge
        arr = mv && !mk && !ps;
        if (rst) begin
            q.delete(); md_v = 0; md_i = NOP; md_pc = 32'h0; md_pc4 = 32'h0;
        end else if (fd) begin
            q.delete(); md_v = 0; md_i = NOP;
        end else if (sd) begin
            if (arr) q.push_back(ma);
        end else begin
            if (arr) q.push_back(ma);
            if (q.size() > 0) begin
                md_pc = q.pop_front(); md_v = 1; md_i = md_pc ^ XORK; md_pc4 = md_pc + 32'd4;
            end else begin
                md_v = 0; md_i = NOP;
            end
        end
        // A fetch goes out only with nothing outstanding and nowhere to lose the answer
        exp_req = !rst && !sf && !ps && !pend && !(mv && mk) && (q.size() == 0);
        if (rst) chk("req_in_reset", {31'h0, ImemReq}, 32'h0);
        else begin
            chk("imem_req", {31'h0, ImemReq}, {31'h0, exp_req});
            chk("imem_addr", ImemAddr, exp_pc);
        end
        if (rst) exp_pc = 32'h0;
        else if (ps) begin exp_pc = tgt; if (pend) pkill = 1; end
        else if (ImemReq) begin
            pend = 1; pkill = 0; paddr = exp_pc; exp_pc = exp_pc + 32'd4;
            pcnt = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 3));
        end
        if (rst) begin n2 = 0; req2_prev = 0; end
        else begin
            req2_prev = ImemReq2;
            if (ImemReq2) begin
                n2++;
                if (n2 == 1)      chk("wrap_addr0", ImemAddr2, 32'hFFFF_FFFC);
                else if (n2 == 2) chk("wrap_addr1", ImemAddr2, 32'h0);
            end
        end
        @(posedge CLK);
        #1;
        chk("validd", {31'h0, ValidD}, {31'h0, md_v});
        chk("instrd", InstrD, md_i);
        if (md_v || rst) begin
            chk("pcd", PCD, md_pc);
            chk("pcplus4d", PCPlus4D, md_pc4);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 32'h0);
    endtask

    initial begin
        bit          r_rst, r_sf, r_sd, r_fd, r_ps;
        logic [31:0] r_tgt;

        // Straight-line fetch with 1-cycle memory
        lat_fix = 1;
        step(1, 0, 0, 0, 0, 32'h0);
        step(1, 0, 0, 0, 0, 32'h0);
        run(8);
        // Decode stall while a response lands in the skid buffer
        step(0, 0, 1, 0, 0, 32'h0);
        step(0, 0, 1, 0, 0, 32'h0);
        step(0, 0, 1, 0, 0, 32'h0);
        run(5);
        // Redirect over an outstanding 3-cycle fetch of 0x20
        step(1, 0, 0, 0, 0, 32'h0);
        lat_fix = 3;
        step(0, 0, 0, 1, 1, 32'h20);
        run(2);
        step(0, 0, 0, 1, 1, 32'h100);
        lat_fix = 1;
        run(6);
        // Redirect in the same cycle as the response
        step(1, 0, 0, 0, 0, 32'h0);
        lat_fix = 2;
        run(2);
        step(0, 0, 0, 1, 1, 32'h200);
        lat_fix = 1;
        run(5);
        // Flush on top of a stall with a full buffer
        step(1, 0, 0, 0, 0, 32'h0);
        run(1);
        step(0, 0, 1, 0, 0, 32'h0);
        step(0, 0, 1, 1, 0, 32'h0);
        run(4);
        // Reset while a fetch is outstanding
        lat_fix = 3;
        run(2);
        step(1, 0, 0, 0, 0, 32'h0);
        lat_fix = 1;
        run(4);
        // Randomised traffic with variable latency
        lat_fix = 0;
        for (int i = 0; i < 3000; i++) begin
            r_rst = ($urandom_range(0, 199) == 0);
            r_sf  = ($urandom_range(0, 4) == 0);
            r_sd  = ($urandom_range(0, 4) == 0);
            r_ps  = ($urandom_range(0, 19) == 0);
            r_fd  = r_ps || ($urandom_range(0, 9) == 0);
            r_tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            step(r_rst, r_sf, r_sd, r_fd, r_ps, r_tgt);
        end
        run(6);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
